// File: rtl/alu_iter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_iter_pkg                                                       |
// | Opcode and FSM state encodings plus latency constants for alu_iter |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package alu_iter_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_REM   = 4'd14,
    OP_REMU  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Acceptance-to-out_valid latency is WIDTH plus these for the iterative ops.
  localparam int c_LAT_MUL_EXTRA = 1;
  localparam int c_LAT_DIV_EXTRA = 2;

endpackage
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_iter_muldiv                                                    |
// | Bit-serial shift-add multiplier / restoring divider sharing one    |
// | adder and one {hi,lo} shift register. Divider under ALU_ITER_DIV_EN|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alu_iter_muldiv
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_div,
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int c_CW = $clog2(WIDTH) + 1;
  // Busy cycles are latency-1, so the final busy cycle has index latency-2.
  localparam logic [c_CW-1:0] c_LAST_MUL = c_CW'(WIDTH + c_LAT_MUL_EXTRA - 2);
  localparam logic [c_CW-1:0] c_LAST_DIV = c_CW'(WIDTH + c_LAT_DIV_EXTRA - 2);

  logic             r_busy;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mc;
  logic [1:0]       r_sel;

  logic             w_div;
  logic [WIDTH-1:0] w_lo_init;
  logic [WIDTH-1:0] w_mc_init;
  logic [WIDTH-1:0] w_div_res;
  logic [WIDTH-1:0] w_mul_res;
  logic [WIDTH+1:0] w_x;
  logic [WIDTH+1:0] w_y;
  logic [WIDTH+1:0] w_sum;
  logic             w_cin;

`ifdef ALU_ITER_DIV_EN
  logic             r_div;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  // Division runs on magnitudes; signs are restored in the fixup cycle.
  assign w_mag_a   = (!i_sel[0] && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mag_b   = (!i_sel[0] && i_b[WIDTH-1]) ? -i_b : i_b;
  assign w_div     = r_div;
  assign w_lo_init = i_div ? w_mag_a : i_b;
  assign w_mc_init = i_div ? w_mag_b : i_a;
  assign w_div_res = r_sel[1] ? (r_rneg ? -r_hi : r_hi) : (r_qneg ? -r_lo : r_lo);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= 1'b0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (i_start) begin
      r_div  <= i_div;
      r_qneg <= !i_sel[0] && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_rneg <= !i_sel[0] && i_a[WIDTH-1];
    end
  end
`else
  logic w_unused_div;

  assign w_div        = 1'b0;
  assign w_lo_init    = i_b;
  assign w_mc_init    = i_a;
  assign w_div_res    = '0;
  assign w_unused_div = ^{i_div, r_sel[1]};
`endif

  // Shared adder: mul adds the multiplicand, div subtracts the divisor.
  always_comb begin
    w_x   = {2'b00, r_hi};
    w_y   = r_lo[0] ? {2'b00, r_mc} : '0;
    w_cin = 1'b0;
    if (w_div) begin
      w_x   = {1'b0, r_hi, r_lo[WIDTH-1]};
      w_y   = ~{2'b00, r_mc};
      w_cin = 1'b1;
    end
  end

  assign w_sum     = w_x + w_y + {{(WIDTH+1){1'b0}}, w_cin};
  assign w_mul_res = r_sel[0] ? w_sum[WIDTH:1] : {w_sum[0], r_lo[WIDTH-1:1]};
  assign o_done    = r_busy && (r_cnt == (w_div ? c_LAST_DIV : c_LAST_MUL));
  assign o_result  = w_div ? w_div_res : w_mul_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_mc   <= '0;
      r_sel  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= w_lo_init;
      r_mc   <= w_mc_init;
      r_sel  <= i_sel;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_busy <= 1'b0;
      if (!w_div) begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end else if (r_cnt != c_LAST_DIV) begin
        if (!w_sum[WIDTH+1]) begin
          r_hi <= w_sum[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_x[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_iter                                                           |
// | Valid/ready ALU: single-cycle ops plus iterative MUL/DIV. Divide   |
// | ops are implemented only when ALU_ITER_DIV_EN is defined.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int c_SHW = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  state_e           w_dest;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  op_e              w_op;
  logic [c_SHW-1:0] w_sh;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_res;
  logic             w_single;
  logic             w_go_mul;
  logic             w_go_div;
  logic             w_illegal;
  logic             w_accept;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_res;

  assign w_op = op_e'(op);
  assign w_sh = b[c_SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = a + b;
      OP_SUB:  w_alu = a - b;
      OP_AND:  w_alu = a & b;
      OP_OR:   w_alu = a | b;
      OP_XOR:  w_alu = a ^ b;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  w_alu = a << w_sh;
      OP_SRL:  w_alu = a >> w_sh;
      OP_SRA:  w_alu = $signed(a) >>> w_sh;
      default: w_alu = '0;
    endcase
  end

  // Route the op: single-cycle result, or hand off to the iterative unit.
  always_comb begin
    w_res     = w_alu;
    w_single  = 1'b1;
    w_go_mul  = 1'b0;
    w_go_div  = 1'b0;
    w_illegal = 1'b0;
    case (w_op)
      OP_MUL, OP_MULHU: begin
        w_single = 1'b0;
        w_go_mul = 1'b1;
      end
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
`ifdef ALU_ITER_DIV_EN
        if (b == '0) begin
          w_res = op[1] ? a : '1;
        end else if (!op[0] && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
          w_res = op[1] ? '0 : a;
        end else begin
          w_single = 1'b0;
          w_go_div = 1'b1;
        end
`else
        w_res     = '0;
        w_illegal = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == ST_IDLE) || (r_state == ST_DONE && out_ready);
    out_valid   = (r_state == ST_DONE);
    w_accept    = in_valid && in_ready && !rst;
    w_dest      = w_go_mul ? ST_MUL : (w_go_div ? ST_DIV : ST_DONE);
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_dest;
      ST_MUL:  if (w_md_done) w_state_nxt = ST_DONE;
      ST_DIV:  if (w_md_done) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = w_accept ? w_dest : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept && w_single) begin
      r_result  <= w_res;
      r_zero    <= (w_res == '0);
      r_illegal <= w_illegal;
    end else if (w_md_done) begin
      r_result  <= w_md_res;
      r_zero    <= (w_md_res == '0);
      r_illegal <= 1'b0;
    end
  end

  assign result  = r_result;
  assign zero    = r_zero;
  assign illegal = r_illegal;

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept && (w_go_mul || w_go_div)),
    .i_div    (w_go_div),
    .i_sel    (op[1:0]),
    .i_a      (a),
    .i_b      (b),
    .o_done   (w_md_done),
    .o_result (w_md_res)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_iter                                                        |
// | Self-checking bench for alu_iter (WIDTH=32) against a reference    |
// | model; divide expectations follow ALU_ITER_DIV_EN.                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill, output int lat);
    logic [63:0] p;
    int sx, sy;
    sx = x;
    sy = y;
    ill = 1'b0;
    lat = 1;
    r = '0;
    p = {32'd0, x} * {32'd0, y};
    case (o)
      4'd0: r = x + y;
      4'd1: r = x - y;
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: r = (x < y) ? 32'd1 : 32'd0;
      4'd7: r = x << y[4:0];
      4'd8: r = x >> y[4:0];
      4'd9: r = $signed(x) >>> y[4:0];
      4'd10: begin r = p[31:0];  lat = 33; end
      4'd11: begin r = p[63:32]; lat = 33; end
      default: begin
`ifdef ALU_ITER_DIV_EN
        if (y == 0) r = (o >= 4'd14) ? x : 32'hFFFF_FFFF;
        else if ((o == 4'd12 || o == 4'd14) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          r = (o == 4'd12) ? x : 32'd0;
        else begin
          lat = 34;
          case (o)
            4'd12:   r = sx / sy;
            4'd13:   r = x / y;
            4'd14:   r = sx % sy;
            default: r = x % y;
          endcase
        end
`else
        r = '0;
        ill = 1'b1;
`endif
      end
    endcase
  endfunction

  // One transaction: present, wait for the result (garbage on the inputs meanwhile), consume.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] got);
    logic [31:0] er;
    logic ei;
    int lat, k;
    model(o, x, y, er, ei, lat);
    out_ready = 1'b0;
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    op = 4'($urandom); a = $urandom; b = $urandom;
    k = 0;
    while (out_valid !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (k + 1 != lat) begin
      errors++;
      $display("FAIL latency op=%0d: got %0d cycles, expected %0d", o, k + 1, lat);
    end
    checks++;
    if (result !== er) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h: got %h, expected %h", o, x, y, result, er);
    end
    checks++;
    if (zero !== (er == 0)) begin
      errors++;
      $display("FAIL zero op=%0d: got %b, expected %b", o, zero, (er == 0));
    end
    checks++;
    if (illegal !== ei) begin
      errors++;
      $display("FAIL illegal op=%0d: got %b, expected %b", o, illegal, ei);
    end
    got = result;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL consume op=%0d: out_valid got %b, expected 0", o, out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
    checks++;
    if (result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: result=%h zero=%b illegal=%b, expected 0/0/0", result, zero, illegal);
    end
  endtask

  task automatic test_directed;
    logic [31:0] got;
    run_op(4'd0, 32'hFFFF_FFFF, 32'd1, got);
    checks++; if (got !== 32'd0) begin errors++; $display("FAIL add_wrap: got %h, expected 0", got); end
    run_op(4'd9, 32'h8000_0000, 32'h0000_0024, got);
    checks++; if (got !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h, expected f8000000", got); end
    run_op(4'd5, 32'hFFFF_FFFF, 32'd0, got);
    checks++; if (got !== 32'd1) begin errors++; $display("FAIL slt: got %h, expected 1", got); end
    run_op(4'd6, 32'hFFFF_FFFF, 32'd0, got);
    checks++; if (got !== 32'd0) begin errors++; $display("FAIL sltu: got %h, expected 0", got); end
    run_op(4'd10, 32'h0001_0001, 32'h0001_0001, got);
    checks++; if (got !== 32'h0002_0001) begin errors++; $display("FAIL mul: got %h, expected 00020001", got); end
    run_op(4'd11, 32'h0001_0001, 32'h0001_0001, got);
    checks++; if (got !== 32'h0000_0001) begin errors++; $display("FAIL mulhu: got %h, expected 00000001", got); end
`ifdef ALU_ITER_DIV_EN
    run_op(4'd12, 32'hFFFF_FFF9, 32'd2, got);
    checks++; if (got !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div: got %h, expected fffffffd", got); end
    run_op(4'd14, 32'hFFFF_FFF9, 32'd2, got);
    checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem: got %h, expected ffffffff", got); end
    run_op(4'd13, 32'd5, 32'd0, got);
    checks++; if (got !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by0: got %h, expected ffffffff", got); end
    run_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, got);
    checks++; if (got !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf: got %h, expected 80000000", got); end
    run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, got);
    checks++; if (got !== 32'd0) begin errors++; $display("FAIL rem_ovf: got %h, expected 0", got); end
`else
    run_op(4'd12, 32'hFFFF_FFF9, 32'd2, got);
    checks++; if (got !== 32'd0) begin errors++; $display("FAIL div_disabled: got %h, expected 0", got); end
`endif
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [31:0] got;
    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), got);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] xs[6], ys[6], er;
    logic [3:0]  os[6];
    logic        ei;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      os[i] = 4'($urandom_range(0, 9)); xs[i] = pick(); ys[i] = pick();
    end
    out_ready = 1'b1;
    in_valid = 1'b1; op = os[0]; a = xs[0]; b = ys[0];
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      model(os[i], xs[i], ys[i], er, ei, lat);
      checks++;
      if (out_valid !== 1'b1 || result !== er || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d] op=%0d: valid=%b ready=%b result=%h, expected 1/1/%h",
                 i, os[i], out_valid, in_ready, result, er);
      end
      if (i < 5) begin op = os[i+1]; a = xs[i+1]; b = ys[i+1]; end
      else in_valid = 1'b0;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [31:0] x, y, held;
    x = $urandom; y = $urandom; held = x + y;
    out_ready = 1'b0;
    in_valid = 1'b1; op = 4'd0; a = x; b = y;
    @(posedge clk); #1;
    a = $urandom; b = $urandom;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: valid=%b ready=%b result=%h, expected 1/0/%h",
                 i, out_valid, in_ready, result, held);
      end
      @(posedge clk); #1;
    end
    x = $urandom; y = $urandom;
    op = 4'd0; a = x; b = y; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready: in_ready got %b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== x + y) begin
      errors++; $display("FAIL release_accept: valid=%b result=%h, expected 1/%h", out_valid, result, x + y);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] got;
    int seen;
    out_ready = 1'b1;
    in_valid = 1'b1; op = 4'd10; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b valid=%b result=%h, expected 1/0/0", in_ready, out_valid, result);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_discard: out_valid high %0d cycles, expected 0", seen);
    end
    run_op(4'd0, 32'd2, 32'd3, got);
    checks++;
    if (got !== 32'd5) begin errors++; $display("FAIL add_after_reset: got %h, expected 5", got); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
